bsg_mcl_host_packet_serdes: RTL and testbench
=============================================

# bsg_mcl_host_packet_serdes

Host-side counterpart of the manycore endpoint FIFO bridge: converts between a 32-bit host word stream and the 128-bit MCL packet FIFOs. The TX path packs four host words into one 128-bit packet and presents it to the bridge's `fifo_v_i`/`fifo_data_i`/`fifo_rdy_o` side. The RX path buffers 128-bit packets from the bridge's `fifo_v_o`/`fifo_data_o`/`fifo_rdy_i` side and unpacks each into four host words. One instance serves one bridge FIFO pair, either request or response.

## Interface
Parameters:
- `rx_els_p`, 2: RX packet buffer depth in 128-bit packets; must be ≥1.
- `fifo_width_lp` (localparam), 128: packet width.
- `word_width_lp` (localparam), 32: host word width.
- `rx_cnt_width_lp` (localparam), `$clog2(4*rx_els_p+1)`: width of `rx_words_o`.

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `tx_v_i`  in  1  host word valid.
- `tx_data_i`  in  32  host word.
- `tx_ready_o`  out  1  TX word accepted when `tx_v_i & tx_ready_o`.
- `fifo_v_o`  out  1  assembled packet valid, to bridge.
- `fifo_data_o`  out  128  assembled packet.
- `fifo_ready_i`  in  1  bridge accepts packet.
- `fifo_v_i`  in  1  packet valid, from bridge.
- `fifo_data_i`  in  128  packet from bridge.
- `fifo_ready_o`  out  1  RX buffer can accept a packet.
- `rx_v_o`  out  1  host word available.
- `rx_data_o`  out  32  current host word.
- `rx_ready_i`  in  1  host consumes word.
- `tx_words_o`  out  3  TX occupancy in words (0–7).
- `rx_words_o`  out  `rx_cnt_width_lp`  RX words available.

## Operation
- Word order on both paths: word 0 maps to packet bits [31:0], word 3 to bits [127:96]. Word 0 is the first word written (TX) and the first word read (RX).
- TX state:
  - 2-bit `tx_cnt_r` (0..3).
  - Three 32-bit shadow words.
  - Output register `out_data_r`/`out_v_r`.
- TX accept:
  - Each accepted word writes shadow[`tx_cnt_r`] and increments `tx_cnt_r`.
  - When `tx_cnt_r==3`, the word is accepted only if the output slot is free, i.e. `~out_v_r | fifo_ready_i`. It is then concatenated with the shadow words into `out_data_r`, `out_v_r` is set, and `tx_cnt_r` wraps 3→0.
  - `tx_ready_o = (tx_cnt_r!=3) | ~out_v_r | fifo_ready_i`.
- TX output:
  - `out_v_r` clears on `fifo_ready_i` unless it is reloaded in the same cycle.
  - `fifo_v_o=out_v_r`, `fifo_data_o=out_data_r`.
- RX buffer:
  - Circular buffer of `rx_els_p` packets with read and write pointers (wrap at `rx_els_p-1`), packet count, and 2-bit word index `rd_idx_r`.
  - `fifo_ready_o = (count != rx_els_p)`.
  - A packet is pushed on `fifo_v_i & fifo_ready_o`.
- RX read:
  - `rx_v_o = (count != 0)`.
  - `rx_data_o = head[32*rd_idx_r +: 32]`.
  - On `rx_v_o & rx_ready_i`, `rd_idx_r` increments. When `rd_idx_r==3` it wraps to 0 and the head packet is popped.
- Simultaneous push and pop: allowed whenever `fifo_ready_o`=1. When full, push is blocked even if a pop occurs in the same cycle.
- Reset mid-operation: partially assembled TX words, the pending TX packet, and all RX contents are discarded.

## Timing
- Reset values: `tx_ready_o`=1, `fifo_v_o`=0, `fifo_data_o`=0, `fifo_ready_o`=1, `rx_v_o`=0, `rx_data_o`=0, `tx_words_o`=0, `rx_words_o`=0. All counters and pointers are 0.
- TX latency: 4th word accepted in cycle N → `fifo_v_o`=1 in cycle N+1.
- TX throughput: one word per cycle sustained while `fifo_ready_i`=1.
- RX latency: packet pushed in cycle N → `rx_v_o`=1 in cycle N+1. Storage is registered; there is no combinational bypass.
- RX throughput: one word per cycle.
- No combinational path from `fifo_ready_i` to `fifo_v_o`, or from `rx_ready_i` to `fifo_ready_o`.
- `tx_ready_o` depends combinationally on `fifo_ready_i`. This is the only such path.

## Configuration
- `BSG_MCL_SERDES_OCC_EN`:
  - Defined: `tx_words_o = tx_cnt_r + 4*out_v_r` and `rx_words_o = 4*count - rd_idx_r`, both registered and updated the cycle after each handshake.
  - Undefined: both ports are tied to 0 and the counting logic is removed.
  - Data path behaviour is identical in both cases.

## Test plan
- TX pack: write 0x11111111, 0x22222222, 0x33333333, 0x44444444 with `fifo_ready_i`=1 → one cycle later, `fifo_data_o`=0x44444444_33333333_22222222_11111111 and `fifo_v_o` pulses for one cycle.
- TX backpressure: `fifo_ready_i`=0, write 8 words → `tx_ready_o` drops after the 7th accepted word and `tx_words_o`=7 (OCC_EN). Raising `fifo_ready_i` drains packet 1 and accepts the 8th word in the same cycle.
- RX unpack: push 0xDDDD…_CCCC…_BBBB…_AAAA… with `rx_ready_i`=1 → `rx_data_o` is 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0xDDDDDDDD on consecutive cycles, then `rx_v_o`=0.
- RX full/wrap with `rx_els_p`=2 and `rx_ready_i`=0:
  - Push 3 packets → `fifo_ready_o`=0 after 2 pushes and `rx_words_o`=8.
  - Read 4 words → third packet is accepted; pointer wraps and order is preserved.
- Simultaneous events: with count=1 and `rd_idx_r`=3, push and pop in the same cycle → count remains 1 and the next word is word 0 of the new packet.
- Reset mid-operation: assert `reset_i` after 2 TX words and 1 RX word → all outputs return to reset values immediately. The next 4 TX words form a clean packet.

Source files
------------

// File: rtl/bsg_mcl_host_packet_serdes.sv
// Host word <-> 128-bit MCL packet serdes: TX packs 4 words per packet, RX buffers packets and unpacks to words.
// Define BSG_MCL_SERDES_OCC_EN to build the registered tx_words_o/rx_words_o occupancy counters.
module bsg_mcl_host_packet_serdes #(
  parameter int rx_els_p = 2,
  localparam int fifo_width_lp = 128,
  localparam int word_width_lp = 32,
  localparam int rx_cnt_width_lp = $clog2(4*rx_els_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tx_v_i,
  input  logic [word_width_lp-1:0]   tx_data_i,
  output logic                       tx_ready_o,
  output logic                       fifo_v_o,
  output logic [fifo_width_lp-1:0]   fifo_data_o,
  input  logic                       fifo_ready_i,
  input  logic                       fifo_v_i,
  input  logic [fifo_width_lp-1:0]   fifo_data_i,
  output logic                       fifo_ready_o,
  output logic                       rx_v_o,
  output logic [word_width_lp-1:0]   rx_data_o,
  input  logic                       rx_ready_i,
  output logic [2:0]                 tx_words_o,
  output logic [rx_cnt_width_lp-1:0] rx_words_o
);

  localparam int ptr_w_lp = (rx_els_p > 1) ? $clog2(rx_els_p) : 1;
  localparam int cnt_w_lp = $clog2(rx_els_p+1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(rx_els_p-1);
  localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(rx_els_p);

  // ---------------- TX ----------------
  logic [1:0]                     tx_cnt_q, tx_cnt_d;
  logic [2:0][word_width_lp-1:0]  shadow_q;
  logic                           out_v_q, out_v_d;
  logic [fifo_width_lp-1:0]       out_data_q;
  logic                           tx_fire, tx_last;

  assign tx_ready_o  = (tx_cnt_q != 2'd3) | ~out_v_q | fifo_ready_i;
  assign tx_fire     = tx_v_i & tx_ready_o;
  assign tx_last     = tx_fire & (tx_cnt_q == 2'd3);
  assign fifo_v_o    = out_v_q;
  assign fifo_data_o = out_data_q;

  always_comb begin
    tx_cnt_d = tx_fire ? tx_cnt_q + 2'd1 : tx_cnt_q;
    out_v_d  = tx_last | (out_v_q & ~fifo_ready_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_cnt_q   <= '0;
      shadow_q   <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      out_v_q  <= out_v_d;
      if (tx_fire) begin
        case (tx_cnt_q)
          2'd0:    shadow_q[0] <= tx_data_i;
          2'd1:    shadow_q[1] <= tx_data_i;
          2'd2:    shadow_q[2] <= tx_data_i;
          default: out_data_q  <= {tx_data_i, shadow_q};
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  logic [3:0][word_width_lp-1:0] mem_q [rx_els_p];
  logic [ptr_w_lp-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]           count_q, count_d;
  logic [1:0]                    rd_idx_q, rd_idx_d;
  logic                          push, rd_fire, pop;

  assign fifo_ready_o = (count_q != els_cnt_lp);
  assign rx_v_o       = (count_q != '0);
  assign rx_data_o    = mem_q[rd_ptr_q][rd_idx_q];
  assign push         = fifo_v_i & fifo_ready_o;
  assign rd_fire      = rx_v_o & rx_ready_i;
  assign pop          = rd_fire & (rd_idx_q == 2'd3);

  always_comb begin
    rd_idx_d = rd_fire ? rd_idx_q + 2'd1 : rd_idx_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset too, so rx_data_o reads zero out of reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < rx_els_p; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_idx_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= fifo_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
    end
  end

`ifdef BSG_MCL_SERDES_OCC_EN
  logic [2:0]                 tx_words_q;
  logic [rx_cnt_width_lp-1:0] rx_words_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_words_q <= '0;
      rx_words_q <= '0;
    end else begin
      tx_words_q <= {out_v_d, tx_cnt_d};
      rx_words_q <= rx_cnt_width_lp'({count_d, 2'b00}) - rx_cnt_width_lp'(rd_idx_d);
    end
  end

  assign tx_words_o = tx_words_q;
  assign rx_words_o = rx_words_q;
`else
  assign tx_words_o = '0;
  assign rx_words_o = '0;
`endif

endmodule

// File: tb/tb_bsg_mcl_host_packet_serdes.sv
// Scoreboard bench for bsg_mcl_host_packet_serdes: directed scenarios then random traffic vs a word-count model.
module tb_bsg_mcl_host_packet_serdes;
  localparam int ELS = 2;
  localparam int RXW = $clog2(4*ELS+1);

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           tx_v_i;
  logic [31:0]    tx_data_i;
  logic           tx_ready_o;
  logic           fifo_v_o;
  logic [127:0]   fifo_data_o;
  logic           fifo_ready_i;
  logic           fifo_v_i;
  logic [127:0]   fifo_data_i;
  logic           fifo_ready_o;
  logic           rx_v_o;
  logic [31:0]    rx_data_o;
  logic           rx_ready_i;
  logic [2:0]     tx_words_o;
  logic [RXW-1:0] rx_words_o;

  always #5 clk_i = ~clk_i;

  bsg_mcl_host_packet_serdes #(.rx_els_p(ELS)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .tx_v_i(tx_v_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .fifo_v_o(fifo_v_o), .fifo_data_o(fifo_data_o), .fifo_ready_i(fifo_ready_i),
    .fifo_v_i(fifo_v_i), .fifo_data_i(fifo_data_i), .fifo_ready_o(fifo_ready_o),
    .rx_v_o(rx_v_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
    .tx_words_o(tx_words_o), .rx_words_o(rx_words_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] tx_exp_q [$];
  logic [31:0]  rx_exp_q [$];
  int           tx_occ;      // words held in the TX path (partial + pending packet)
  int           rx_occ;      // unread words in the RX buffer
  logic [31:0]  tx_part [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int occ_exp(input int v);
`ifdef BSG_MCL_SERDES_OCC_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check_reset_outputs();
    check("rst_tx_ready_o", tx_ready_o, 1);
    check("rst_fifo_v_o", fifo_v_o, 0);
    check("rst_fifo_data_o", fifo_data_o, 0);
    check("rst_fifo_ready_o", fifo_ready_o, 1);
    check("rst_rx_v_o", rx_v_o, 0);
    check("rst_rx_data_o", rx_data_o, 0);
    check("rst_tx_words_o", tx_words_o, 0);
    check("rst_rx_words_o", rx_words_o, 0);
  endtask

  task automatic idle_inputs();
    tx_v_i = 0; tx_data_i = '0; fifo_ready_i = 0;
    fifo_v_i = 0; fifo_data_i = '0; rx_ready_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i); #1;
    reset_i = 1'b1;
    idle_inputs();
    #1;
    check_reset_outputs();
    tx_exp_q.delete();
    rx_exp_q.delete();
    tx_occ = 0;
    rx_occ = 0;
    @(negedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  // One clock of stimulus; the model decides which handshakes complete.
  task automatic cycle(input bit tv, input logic [31:0] td, input bit fr,
                       input bit fv, input logic [127:0] fd, input bit rr);
    bit m_tx_rdy, m_rx_rdy, tx_acc, drain, rx_push, rx_rd;
    @(negedge clk_i); #1;
    m_rx_rdy = ((rx_occ + 3) / 4) != ELS;
    check("fifo_v_o", fifo_v_o, tx_occ >= 4);
    check("fifo_ready_o", fifo_ready_o, m_rx_rdy);
    check("rx_v_o", rx_v_o, rx_occ != 0);
    check("tx_words_o", tx_words_o, occ_exp(tx_occ));
    check("rx_words_o", rx_words_o, occ_exp(rx_occ));
    tx_v_i = tv; tx_data_i = td; fifo_ready_i = fr;
    fifo_v_i = fv; fifo_data_i = fd; rx_ready_i = rr;
    #1;
    m_tx_rdy = !(tx_occ == 7 && !fr);
    check("tx_ready_o", tx_ready_o, m_tx_rdy);
    tx_acc  = tv && m_tx_rdy;
    drain   = (tx_occ >= 4) && fr;
    rx_push = fv && m_rx_rdy;
    rx_rd   = (rx_occ != 0) && rr;
    if (drain) tx_occ -= 4;
    if (tx_acc) begin
      if (tx_occ % 4 == 3) tx_exp_q.push_back({td, tx_part[2], tx_part[1], tx_part[0]});
      else tx_part[tx_occ % 4] = td;
      tx_occ++;
    end
    if (rx_rd) rx_occ--;
    if (rx_push) begin
      rx_occ += 4;
      for (int k = 0; k < 4; k++) rx_exp_q.push_back(fd[32*k +: 32]);
    end
  endtask

  // Monitor: samples just before the active edge, after stimulus has settled
  initial begin
    forever begin
      @(negedge clk_i); #3;
      if (!reset_i && fifo_v_o && fifo_ready_i) begin
        if (tx_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_pkt_unexpected: got %0h, expected none", fifo_data_o);
        end else check("tx_pkt", fifo_data_o, tx_exp_q.pop_front());
      end
      if (!reset_i && rx_v_o && rx_ready_i) begin
        if (rx_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rx_word_unexpected: got %0h, expected none", rx_data_o);
        end else check("rx_word", rx_data_o, rx_exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] p1, p2, p3;
    reset_i = 1'b1;
    idle_inputs();
    tx_occ = 0; rx_occ = 0;
    #2;
    check_reset_outputs();
    @(negedge clk_i); #1;
    reset_i = 1'b0;

    // TX pack
    cycle(1, 32'h11111111, 1, 0, '0, 0);
    cycle(1, 32'h22222222, 1, 0, '0, 0);
    cycle(1, 32'h33333333, 1, 0, '0, 0);
    cycle(1, 32'h44444444, 1, 0, '0, 0);
    check("tx_pack_model", tx_exp_q[0], 128'h44444444_33333333_22222222_11111111);
    repeat (3) cycle(0, '0, 1, 0, '0, 0);

    // TX backpressure: 8th word stalls until the bridge drains packet 1
    for (int i = 1; i <= 7; i++) cycle(1, 32'hA0000000 + i, 0, 0, '0, 0);
    cycle(1, 32'hA0000008, 0, 0, '0, 0);
    cycle(1, 32'hA0000008, 1, 0, '0, 0);
    repeat (3) cycle(0, '0, 1, 0, '0, 0);

    // RX unpack
    cycle(0, '0, 0, 1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1);
    repeat (6) cycle(0, '0, 0, 0, '0, 1);

    // RX full / wrap
    p1 = {32'h13, 32'h12, 32'h11, 32'h10};
    p2 = {32'h23, 32'h22, 32'h21, 32'h20};
    p3 = {32'h33, 32'h32, 32'h31, 32'h30};
    cycle(0, '0, 0, 1, p1, 0);
    cycle(0, '0, 0, 1, p2, 0);
    cycle(0, '0, 0, 1, p3, 0);
    repeat (4) cycle(0, '0, 0, 1, p3, 1);
    cycle(0, '0, 0, 1, p3, 0);
    repeat (10) cycle(0, '0, 0, 0, '0, 1);

    // Simultaneous push and pop with count=1, last word being read
    cycle(0, '0, 0, 1, {32'h53, 32'h52, 32'h51, 32'h50}, 0);
    repeat (3) cycle(0, '0, 0, 0, '0, 1);
    cycle(0, '0, 0, 1, {32'h63, 32'h62, 32'h61, 32'h60}, 1);
    cycle(0, '0, 0, 0, '0, 0);
    repeat (5) cycle(0, '0, 0, 0, '0, 1);

    // Reset mid-operation, then a clean packet
    cycle(1, 32'hBAD00001, 0, 1, {4{32'hBADBAD00}}, 0);
    cycle(1, 32'hBAD00002, 0, 0, '0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 32'hC0DE0000 + i, 1, 0, '0, 0);
    repeat (2) cycle(0, '0, 1, 0, '0, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) != 0);
    end

    repeat (40) cycle(0, '0, 1, 0, '0, 1);
    check("tx_queue_drained", tx_exp_q.size(), 0);
    check("rx_queue_drained", rx_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
